// File: rtl/wb_slave_decoder_pkg.sv
// wb_decoder_pkg: shared state encoding, default watchdog limit and a packed-vector field slicer.
// Contents:
//   ST_IDLE / ST_BUSY / ST_NOHIT  decoder FSM state codes
//   DEFAULT_TIMEOUT               default watchdog limit in stalled cycles
//   field()                       returns field k (width w, w <= 64) of a packed per-slave vector
package wb_decoder_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_NOHIT = 2'd2;
    localparam int DEFAULT_TIMEOUT = 255;
    localparam int FIELD_VEC_MAX = 1024;
    // Packed vectors are zero-extended to FIELD_VEC_MAX bits so one function serves every slave count.
    function automatic logic [63:0] field(input logic [FIELD_VEC_MAX-1:0] vec, input int k, input int w);
        return 64'(vec >> (k * w)) & ((64'd1 << w) - 64'd1);
    endfunction
endpackage

// File: rtl/wb_slave_decoder_if.sv
// wb_slave_decoder_if: single Wishbone master bus between the arbiter output and the slave decoder.
// Signals: cyc, stb, we, adr[AW], sel[DW/8], dat_w[DW] driven by the master;
//          dat_r[DW], ack, err returned by the slave side.
// Modports: master (drives request), slave (drives response).
interface wb_slave_decoder_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic          err;
    modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_addr_match.sv
// wb_addr_match: combinational address decode against per-slave base/mask pairs.
// Ports:
//   adr_i      in   AW   address to decode
//   hit_any_o  out  1    at least one slave region matches
//   hit_idx_o  out  IW   lowest matching slave index (0 when no hit)
module wb_addr_match
    import wb_decoder_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 32,
    parameter logic [N*AW-1:0] BASE = '0,
    parameter logic [N*AW-1:0] MASK = '0,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [AW-1:0] adr_i,
    output logic          hit_any_o,
    output logic [IW-1:0] hit_idx_o
);
    // Scanning from the top down lets the lowest matching index overwrite the others.
    always_comb begin
        hit_any_o = 1'b0;
        hit_idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (((adr_i ^ AW'(field(FIELD_VEC_MAX'(BASE), k, AW))) & AW'(field(FIELD_VEC_MAX'(MASK), k, AW))) == '0) begin
                hit_any_o = 1'b1;
                hit_idx_o = IW'(k);
            end
        end
    end
endmodule

// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder: slave-side Wishbone decoder with region select, response mux and watchdog abort.
// Ports:
//   clock, reset     clock and synchronous active-low reset
//   m                master bus (slave modport): request in, dat_r/ack/err out
//   s_cyc_o/s_stb_o  per-slave cycle/strobe, one-hot or zero
//   s_we_o/s_adr_o/s_sel_o/s_dat_w_o  broadcast copies of the master request
//   s_dat_r_i/s_ack_i/s_err_i         per-slave responses
//   done_o           bus free, arbiter may regrant
//   busy_o           decoder not idle
module wb_slave_decoder
    import wb_decoder_pkg::*;
#(
    parameter int NUMSLAVES = 4,
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter logic [NUMSLAVES*ADDRWIDTH-1:0] SLAVEBASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NUMSLAVES*ADDRWIDTH-1:0] SLAVEMASK = {4{32'hF000_0000}},
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                           clock,
    input  logic                           reset,
    wb_slave_decoder_if.slave              m,
    output logic [NUMSLAVES-1:0]           s_cyc_o,
    output logic [NUMSLAVES-1:0]           s_stb_o,
    output logic                           s_we_o,
    output logic [ADDRWIDTH-1:0]           s_adr_o,
    output logic [DATAWIDTH/8-1:0]         s_sel_o,
    output logic [DATAWIDTH-1:0]           s_dat_w_o,
    input  logic [NUMSLAVES*DATAWIDTH-1:0] s_dat_r_i,
    input  logic [NUMSLAVES-1:0]           s_ack_i,
    input  logic [NUMSLAVES-1:0]           s_err_i,
    output logic                           done_o,
    output logic                           busy_o
);
    localparam int IW = (NUMSLAVES > 1) ? $clog2(NUMSLAVES) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [1:0]    state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          hit_any;
    logic [IW-1:0] hit_idx;
    logic          s_ack_sel, s_err_sel, in_busy, timeout;

    wb_addr_match #(
        .N(NUMSLAVES), .AW(ADDRWIDTH), .BASE(SLAVEBASE), .MASK(SLAVEMASK)
    ) u_match (
        .adr_i(m.adr), .hit_any_o(hit_any), .hit_idx_o(hit_idx)
    );

    assign s_ack_sel = s_ack_i[sel_q];
    assign s_err_sel = s_err_i[sel_q];
    // Reset gates the responses so a cycle interrupted by reset never reports ack or err.
    assign in_busy = reset & (state_q == ST_BUSY) & m.cyc;
    assign timeout = in_busy & m.stb & ~s_ack_sel & ~s_err_sel & (wdog_q == WW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wdog_q  <= wdog_d;
        end
    end

    // The slave index is latched once per cycle; block transfers stay on it until m.cyc drops.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wdog_d  = wdog_q;
        if (state_q == ST_IDLE) begin
            if (m.cyc && m.stb) begin
                state_d = hit_any ? ST_BUSY : ST_NOHIT;
                sel_d   = hit_any ? hit_idx : sel_q;
                wdog_d  = '0;
            end
        end else if (state_q == ST_BUSY) begin
            state_d = (!m.cyc || timeout) ? ST_IDLE : ST_BUSY;
            wdog_d  = (!m.cyc || timeout || (m.stb && (s_ack_sel || s_err_sel))) ? '0 :
                      m.stb ? wdog_q + WW'(1) : wdog_q;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        m.dat_r = in_busy ? s_dat_r_i[sel_q*DATAWIDTH +: DATAWIDTH] : '0;
        m.ack   = in_busy & m.stb & s_ack_sel & ~s_err_sel;
        m.err   = (in_busy & m.stb & s_err_sel) | timeout | (reset & (state_q == ST_NOHIT));
        s_cyc_o = in_busy ? NUMSLAVES'(1) << sel_q : '0;
        s_stb_o = in_busy ? NUMSLAVES'(m.stb) << sel_q : '0;
    end

    assign s_we_o    = m.we;
    assign s_adr_o   = m.adr;
    assign s_sel_o   = m.sel;
    assign s_dat_w_o = m.dat_w;
    assign done_o    = (state_q == ST_IDLE) & ~m.cyc;
    assign busy_o    = state_q != ST_IDLE;
endmodule

// File: tb/tb_wb_slave_decoder.sv
// tb_wb_slave_decoder: directed-vector bench for wb_slave_decoder with simple registered slave models.
module tb_wb_slave_decoder;
    localparam int N = 4, AW = 32, DW = 32;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    wb_slave_decoder_if #(.AW(AW), .DW(DW)) m_if ();
    logic [N-1:0]    s_cyc, s_stb, s_ack, s_err, ack_en, err_en, resp_q;
    logic            s_we, done, busy;
    logic [AW-1:0]   s_adr;
    logic [DW/8-1:0] s_sel;
    logic [DW-1:0]   s_dat_w;
    logic [N*DW-1:0] s_dat_r;
    int n_chk = 0, n_err = 0;

    wb_slave_decoder #(
        .NUMSLAVES(N), .ADDRWIDTH(AW), .DATAWIDTH(DW),
        .SLAVEBASE({32'h2000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVEMASK({32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset), .m(m_if.slave),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_sel_o(s_sel),
        .s_dat_w_o(s_dat_w), .s_dat_r_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err),
        .done_o(done), .busy_o(busy)
    );

    // Each slave answers one cycle after it sees its strobe, then idles a cycle.
    initial resp_q = '0;
    always @(posedge clock) resp_q <= s_stb & ~resp_q;
    assign s_ack   = resp_q & ack_en;
    assign s_err   = resp_q & err_en;
    assign s_dat_r = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0A0A_0A0A};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] adr, input logic we, input int beats,
                        output int acks, output int errs, output int cycles, output logic [31:0] last_dat,
                        output logic [3:0] cyc_or, output logic [3:0] stb_or, output int viol, output logic done_hi);
        logic fin;
        acks = 0; errs = 0; cycles = 0; last_dat = '0; cyc_or = '0; stb_or = '0; viol = 0; done_hi = 1'b0; fin = 1'b0;
        @(posedge clock); #1;
        m_if.cyc = 1'b1; m_if.stb = 1'b1; m_if.we = we; m_if.adr = adr; m_if.sel = 4'hF; m_if.dat_w = adr ^ 32'h5A5A_5A5A;
        #1;
        chk("bcast_adr", 64'(s_adr), 64'(adr));
        chk("bcast_we", 64'(s_we), 64'(we));
        chk("bcast_dat", 64'(s_dat_w), 64'(adr ^ 32'h5A5A_5A5A));
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clock);
            cycles++;
            if ($countones(s_cyc) > 1 || (m_if.ack && m_if.err)) viol++;
            cyc_or |= s_cyc; stb_or |= s_stb; done_hi |= done;
            if (m_if.ack) begin acks++; last_dat = m_if.dat_r; end
            if (m_if.err) errs++;
            fin = (acks == beats) || (errs != 0);
            if (!fin && m_if.ack) begin
                @(posedge clock); #1;
                m_if.adr = m_if.adr + 32'd4; m_if.dat_w = m_if.dat_w + 32'd1;
            end
        end
        chk("xfer_finished", 64'(fin), 64'd1);
        @(posedge clock); #1;
        m_if.cyc = 1'b0; m_if.stb = 1'b0; m_if.we = 1'b0;
    endtask

    int acks, errs, cycles, viol;
    logic [31:0] dat;
    logic [3:0] cyc_or, stb_or;
    logic done_hi;

    initial begin
        m_if.cyc = 1'b0; m_if.stb = 1'b0; m_if.we = 1'b0; m_if.adr = '0; m_if.sel = '0; m_if.dat_w = '0;
        ack_en = 4'b1111; err_en = 4'b0000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ack", 64'(m_if.ack), 64'd0);
        chk("rst_err", 64'(m_if.err), 64'd0);
        chk("rst_scyc", 64'(s_cyc), 64'd0);
        chk("rst_sstb", 64'(s_stb), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd1);
        chk("rst_datr", 64'(m_if.dat_r), 64'd0);
        @(posedge clock); #1 reset = 1'b1;

        // Single read from S1.
        xfer(32'h1000_0004, 1'b0, 1, acks, errs, cycles, dat, cyc_or, stb_or, viol, done_hi);
        chk("rd_acks", 64'(acks), 64'd1);
        chk("rd_errs", 64'(errs), 64'd0);
        chk("rd_cycles", 64'(cycles), 64'd3);
        chk("rd_dat", 64'(dat), 64'hDEAD_BEEF);
        chk("rd_stb", 64'(stb_or), 64'b0010);
        chk("rd_viol", 64'(viol), 64'd0);
        @(negedge clock);
        chk("rd_scyc_drop", 64'(s_cyc), 64'd0);
        @(negedge clock);
        chk("rd_done", 64'(done), 64'd1);
        chk("rd_busy", 64'(busy), 64'd0);

        // Unmapped address.
        xfer(32'h9000_0000, 1'b0, 1, acks, errs, cycles, dat, cyc_or, stb_or, viol, done_hi);
        chk("nh_errs", 64'(errs), 64'd1);
        chk("nh_acks", 64'(acks), 64'd0);
        chk("nh_cycles", 64'(cycles), 64'd2);
        chk("nh_scyc", 64'(cyc_or), 64'd0);
        chk("nh_sstb", 64'(stb_or), 64'd0);
        @(negedge clock);
        chk("nh_err_once", 64'(m_if.err), 64'd0);
        chk("nh_done", 64'(done), 64'd1);

        // S0 stalls forever: watchdog aborts on the 8th stalled BUSY cycle.
        ack_en = 4'b1110;
        xfer(32'h0100_0000, 1'b0, 1, acks, errs, cycles, dat, cyc_or, stb_or, viol, done_hi);
        chk("to_errs", 64'(errs), 64'd1);
        chk("to_acks", 64'(acks), 64'd0);
        chk("to_cycles", 64'(cycles), 64'd9);
        chk("to_stb", 64'(stb_or), 64'b0001);
        @(negedge clock);
        chk("to_scyc_drop", 64'(s_cyc), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
        ack_en = 4'b1111;

        // Four-beat block write to S1.
        xfer(32'h1000_0000, 1'b1, 4, acks, errs, cycles, dat, cyc_or, stb_or, viol, done_hi);
        chk("blk_acks", 64'(acks), 64'd4);
        chk("blk_errs", 64'(errs), 64'd0);
        chk("blk_cycles", 64'(cycles), 64'd9);
        chk("blk_cyc", 64'(cyc_or), 64'b0010);
        chk("blk_done_low", 64'(done_hi), 64'd0);
        chk("blk_viol", 64'(viol), 64'd0);
        repeat (2) @(negedge clock);
        chk("blk_done", 64'(done), 64'd1);

        // S0 and S2 overlap: the lower index wins.
        xfer(32'h0000_0010, 1'b0, 1, acks, errs, cycles, dat, cyc_or, stb_or, viol, done_hi);
        chk("ov_stb", 64'(stb_or), 64'b0001);
        chk("ov_dat", 64'(dat), 64'h0A0A_0A0A);
        chk("ov_acks", 64'(acks), 64'd1);
        repeat (2) @(negedge clock);

        // S1 raises ack and err together: only err reaches the master.
        err_en = 4'b0010;
        xfer(32'h1000_0008, 1'b0, 1, acks, errs, cycles, dat, cyc_or, stb_or, viol, done_hi);
        chk("ae_errs", 64'(errs), 64'd1);
        chk("ae_acks", 64'(acks), 64'd0);
        chk("ae_cycles", 64'(cycles), 64'd3);
        chk("ae_viol", 64'(viol), 64'd0);
        err_en = 4'b0000;
        repeat (2) @(negedge clock);

        // Reset asserted while S0 is stalling.
        ack_en = 4'b1110;
        @(posedge clock); #1;
        m_if.cyc = 1'b1; m_if.stb = 1'b1; m_if.adr = 32'h0100_0000;
        repeat (4) @(negedge clock);
        chk("rs_busy_pre", 64'(busy), 64'd1);
        chk("rs_scyc_pre", 64'(s_cyc), 64'b0001);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("rs_ack_low", 64'(m_if.ack), 64'd0);
        chk("rs_err_low", 64'(m_if.err), 64'd0);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("rs_scyc", 64'(s_cyc), 64'd0);
        chk("rs_sstb", 64'(s_stb), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_wdog", 64'(dut.wdog_q), 64'd0);
        chk("rs_ack", 64'(m_if.ack), 64'd0);
        chk("rs_err", 64'(m_if.err), 64'd0);
        chk("rs_done_cyc", 64'(done), 64'd0);
        m_if.cyc = 1'b0; m_if.stb = 1'b0;
        @(negedge clock);
        chk("rs_done", 64'(done), 64'd1);
        ack_en = 4'b1111;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
